// File: rtl/demux_stream_pkg.sv
// Shared defaults and select helpers for the demux_stream block.
// Broadcast support is enabled by defining DEMUX_STREAM_BCAST_EN.
package demux_stream_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int NCH_DEF   = 8;
  localparam int MAX_NCH   = 256;

  // Returned at the maximum channel count; callers keep the low NCH bits.
  function automatic logic [MAX_NCH-1:0] onehot_dec(input logic [7:0] sel, input int n);
    logic [MAX_NCH-1:0] v;
    v = '0;
    if (int'(sel) < n) v[sel] = 1'b1;
    return v;
  endfunction

  function automatic logic sel_legal(input logic [7:0] sel, input int n);
    return int'(sel) < n;
  endfunction

endpackage

// File: rtl/demux_stream_if.sv
// Producer/consumer bundle for demux_stream; slave is the block side.
// in_bcast exists only when DEMUX_STREAM_BCAST_EN is defined.
interface demux_stream_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 8,
  parameter int SW    = $clog2(NCH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SW-1:0]    in_sel;
`ifdef DEMUX_STREAM_BCAST_EN
  logic             in_bcast;
`endif
  logic [NCH-1:0]   out_valid;
  logic [NCH-1:0]   out_ready;
  logic [WIDTH-1:0] out_data;
  logic             err_pulse;
  logic             err_flag;
  logic             err_clr;

  modport slave (
    input  in_valid, in_data, in_sel, out_ready, err_clr,
`ifdef DEMUX_STREAM_BCAST_EN
    input  in_bcast,
`endif
    output in_ready, out_valid, out_data, err_pulse, err_flag
  );

  modport master (
    output in_valid, in_data, in_sel, out_ready, err_clr,
`ifdef DEMUX_STREAM_BCAST_EN
    output in_bcast,
`endif
    input  in_ready, out_valid, out_data, err_pulse, err_flag
  );
endinterface

// File: rtl/demux_sel_decode.sv
// Per-channel valid decode of the held beat: one-hot on sel for unicast,
// the pending mask for broadcast.
module demux_sel_decode #(
  parameter int NCH = 8,
  parameter int SW  = $clog2(NCH)
) (
  input  logic           valid,
  input  logic [SW-1:0]  sel,
  input  logic           bcast,
  input  logic [NCH-1:0] mask,
  output logic [NCH-1:0] out_valid
);
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign out_valid[k] = valid && (bcast ? mask[k] : (sel == SW'(k)));
  end
endmodule

// File: rtl/demux_stream.sv
// Registered 1-to-NCH stream demux with one-entry pass-through stage,
// out-of-range select drop/error, optional broadcast (DEMUX_STREAM_BCAST_EN).
module demux_stream
  import demux_stream_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NCH   = NCH_DEF,
  parameter int SW    = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst_n,
  demux_stream_if.slave  bus
);
  logic             valid_q;
  logic [SW-1:0]    sel_q;
  logic [WIDTH-1:0] data_q;
  logic             err_pulse_q;
  logic             err_flag_q;
  logic             bcast_q;
  logic [NCH-1:0]   pend_q;
  logic [NCH-1:0]   ov;
  logic             in_bc;
  logic             drain, accept, legal, load, bad;

  demux_sel_decode #(.NCH(NCH), .SW(SW)) u_dec (
    .valid     (valid_q),
    .sel       (sel_q),
    .bcast     (bcast_q),
    .mask      (pend_q),
    .out_valid (ov)
  );

  // Drains once every channel still showing valid is ready; covers unicast
  // (single bit) and the last outstanding channels of a broadcast alike.
  assign drain  = valid_q && ~|(ov & ~bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;
  assign legal  = in_bc || sel_legal(8'(bus.in_sel), NCH);
  assign load   = accept && legal;
  assign bad    = accept && !legal;

  assign bus.in_ready  = !valid_q || drain;
  assign bus.out_valid = ov;
  assign bus.out_data  = data_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_flag  = err_flag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      sel_q       <= '0;
      data_q      <= '0;
      err_pulse_q <= 1'b0;
      err_flag_q  <= 1'b0;
    end else begin
      if (load) begin
        valid_q <= 1'b1;
        sel_q   <= bus.in_sel;
        data_q  <= bus.in_data;
      end else if (drain) begin
        valid_q <= 1'b0;
      end
      err_pulse_q <= bad;
      // A new error wins over a same-cycle clear.
      err_flag_q  <= bad || (err_flag_q && !bus.err_clr);
    end
  end

`ifdef DEMUX_STREAM_BCAST_EN
  assign in_bc = bus.in_bcast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcast_q <= 1'b0;
      pend_q  <= '0;
    end else if (load) begin
      bcast_q <= in_bc;
      pend_q  <= '1;
    end else begin
      pend_q  <= pend_q & ~bus.out_ready;
    end
  end
`else
  assign in_bc   = 1'b0;
  assign bcast_q = 1'b0;
  assign pend_q  = '0;
`endif

endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench for demux_stream (NCH=6 so out-of-range selects exist);
// random and directed beats are checked every cycle against a beat-level model.
module tb_demux_stream;
  localparam int WIDTH = 8;
  localparam int NCH   = 6;
  localparam int SW    = 3;
`ifdef DEMUX_STREAM_BCAST_EN
  localparam bit BCAST_ON = 1'b1;
`else
  localparam bit BCAST_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demux_stream_if #(.WIDTH(WIDTH), .NCH(NCH), .SW(SW)) bus ();

  demux_stream #(.WIDTH(WIDTH), .NCH(NCH), .SW(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: at most one held beat, with the set of channels still owed a copy.
  logic             m_has;
  logic [NCH-1:0]   m_rem;
  logic [WIDTH-1:0] m_data;
  logic             m_ep, m_ef;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_has = 1'b0; m_rem = '0; m_data = '0; m_ep = 1'b0; m_ef = 1'b0;
  endtask

  task automatic drive_idle();
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_sel = '0;
    bus.out_ready = '0; bus.err_clr = 1'b0;
`ifdef DEMUX_STREAM_BCAST_EN
    bus.in_bcast = 1'b0;
`endif
  endtask

  task automatic step(input logic iv, input logic [SW-1:0] sel, input logic [WIDTH-1:0] d,
                      input logic [NCH-1:0] ordy, input logic clr, input logic bc);
    logic [NCH-1:0] e_ov, rem_n;
    logic e_rdy, acc, legal, has_n;
    @(negedge clk);
    bus.in_valid = iv; bus.in_sel = sel; bus.in_data = d;
    bus.out_ready = ordy; bus.err_clr = clr;
`ifdef DEMUX_STREAM_BCAST_EN
    bus.in_bcast = bc;
`endif
    #1;
    e_ov  = m_has ? m_rem : '0;
    e_rdy = !m_has || ((m_rem & ~ordy) == '0);
    chk("out_valid", 32'(bus.out_valid), 32'(e_ov));
    chk("in_ready",  32'(bus.in_ready),  32'(e_rdy));
    if (m_has) chk("out_data", 32'(bus.out_data), 32'(m_data));
    chk("err_pulse", 32'(bus.err_pulse), 32'(m_ep));
    chk("err_flag",  32'(bus.err_flag),  32'(m_ef));
    // Advance the model to the state after the coming rising edge.
    acc   = iv && e_rdy;
    legal = (bc && BCAST_ON) || (int'(sel) < NCH);
    rem_n = m_rem & ~ordy;
    has_n = m_has && (rem_n != '0);
    m_rem = rem_n;
    m_has = has_n;
    if (acc && legal) begin
      m_has = 1'b1;
      m_data = d;
      if (bc && BCAST_ON) m_rem = '1;
      else begin m_rem = '0; m_rem[sel] = 1'b1; end
    end
    m_ef = (acc && !legal) || (m_ef && !clr);
    m_ep = acc && !legal;
  endtask

  initial begin
    drive_idle();
    model_reset();
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data",  32'(bus.out_data),  32'h0);
    chk("rst_err_pulse", 32'(bus.err_pulse), 32'h0);
    chk("rst_err_flag",  32'(bus.err_flag),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Route each legal channel back to back, consumers always ready.
    for (int i = 0; i < NCH; i++)
      step(1'b1, SW'(i), 8'hA0 + 8'(i), '1, 1'b0, 1'b0);
    step(1'b0, '0, '0, '1, 1'b0, 1'b0);

    // Back-pressure on channel 3 with a second beat stalled behind it.
    step(1'b1, 3'd3, 8'h5C, '1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      step(1'b1, 3'd1, 8'h33, 6'b110111, 1'b0, 1'b0);
    step(1'b1, 3'd1, 8'h33, '1, 1'b0, 1'b0);
    step(1'b0, '0, '0, '1, 1'b0, 1'b0);

    // Ready on every channel except the selected one must not drain.
    step(1'b1, 3'd2, 8'h42, '1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b0, '0, '0, 6'b111011, 1'b0, 1'b0);
    step(1'b0, '0, '0, '1, 1'b0, 1'b0);

    // Illegal selects, set-over-clear priority, then a plain clear.
    step(1'b1, 3'd7, 8'h11, '1, 1'b0, 1'b0);
    step(1'b1, 3'd6, 8'h12, '1, 1'b1, 1'b0);
    step(1'b0, '0, '0, '1, 1'b1, 1'b0);
    step(1'b0, '0, '0, '1, 1'b0, 1'b0);
    step(1'b0, '0, '0, '1, 1'b0, 1'b0);

    // Reset asserted while a beat is held on channel 5, with the flag set.
    step(1'b1, 3'd7, 8'h01, '1, 1'b0, 1'b0);
    step(1'b1, 3'd5, 8'h77, '0, 1'b0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b0, 1'b0);
    chk("hold_ch5", 32'(bus.out_valid), 32'h20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(bus.out_valid), 32'h0);
    chk("async_err_flag",  32'(bus.err_flag),  32'h0);
    chk("async_in_ready",  32'(bus.in_ready),  32'h1);
    drive_idle();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

`ifdef DEMUX_STREAM_BCAST_EN
    // Broadcast served in two groups of channels, no duplicate beat.
    step(1'b1, 3'd7, 8'hEE, '1, 1'b0, 1'b1);
    step(1'b1, 3'd4, 8'h44, 6'b000111, 1'b0, 1'b0);
    step(1'b1, 3'd4, 8'h44, 6'b000000, 1'b0, 1'b0);
    step(1'b1, 3'd4, 8'h44, 6'b111000, 1'b0, 1'b0);
    step(1'b0, '0, '0, '1, 1'b0, 1'b0);
    step(1'b0, '0, '0, '1, 1'b0, 1'b0);
`endif

    // Random traffic; selects span the illegal codes 6 and 7.
    for (int i = 0; i < 2000; i++)
      step(($urandom_range(0, 9) < 7), SW'($urandom_range(0, 7)), WIDTH'($urandom),
           NCH'($urandom), ($urandom_range(0, 15) == 0),
           BCAST_ON && ($urandom_range(0, 3) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
